ps2_key_encoder: RTL

//  Producer side of the ps2_key event word consumed by the core input decoders.

---
 rtl/ps2_pkg.sv | 17 +
 rtl/ps2_line_filter.sv | 35 +++
 rtl/ps2_key_encoder.sv | 105 ++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM states, prefix byte constants and the ps2_key event layout.
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  typedef struct packed {
    logic       toggle;
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } ps2_key_t;
  // BAT, ACK, echo, resend and overrun replies carry no key information
  function automatic logic is_status(input logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  endfunction
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchroniser plus FILTER_LEN glitch filter with edge strobes.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_fall,
  output logic o_edge
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0]    r_sync;
  logic          r_filt;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_sync <= 2'b11;
      r_filt <= 1'b1;
      r_cnt  <= '0;
      o_fall <= 1'b0;
      o_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      o_fall <= 1'b0;
      o_edge <= 1'b0;
      if (r_sync[1] == r_filt) r_cnt <= '0;
      else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_filt <= r_sync[1];
        r_cnt  <= '0;
        o_edge <= 1'b1;
        o_fall <= r_filt;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder: PS/2 frame deserialiser folding E0/F0/E1 prefixes into 11-bit key events.
// Optional frame timeout enabled by defining PS2_KEY_TIMEOUT_EN.
module ps2_key_encoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 6000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        frame_err
);
  logic       w_fall, w_edge, w_data, w_timeout;
  logic [1:0] r_dsync;
  ps2_state_t r_state;
  logic [2:0] r_bitcnt, r_e1_skip;
  logic [7:0] r_sr, r_byte;
  logic       r_par_ok, r_byte_vld, r_ext, r_brk, r_err;
  ps2_key_t   r_key;
  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .i_raw  (ps2_clk_in),
    .o_fall (w_fall),
    .o_edge (w_edge)
  );
  assign w_data    = r_dsync[1];
  assign ps2_key   = r_key;
  assign frame_err = r_err;
`ifdef PS2_KEY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_tcnt;
  assign w_timeout = r_tcnt == TW'(TIMEOUT_CYC);
  always_ff @(posedge clk_sys) begin
    if (!reset_n || r_state == IDLE || w_edge || w_timeout) r_tcnt <= '0;
    else r_tcnt <= r_tcnt + 1'b1;
  end
`else
  assign w_timeout = w_edge & (TIMEOUT_CYC < 0);
`endif
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_dsync    <= 2'b11;
      r_state    <= IDLE;
      r_bitcnt   <= '0;
      r_sr       <= '0;
      r_par_ok   <= 1'b0;
      r_byte_vld <= 1'b0;
      r_byte     <= '0;
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_e1_skip  <= '0;
      r_key      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_dsync    <= {r_dsync[0], ps2_data_in};
      r_err      <= 1'b0;
      r_byte_vld <= 1'b0;
      if (w_timeout) begin
        r_state <= IDLE;
        r_err   <= 1'b1;
      end else if (w_fall) begin
        case (r_state)
          IDLE: begin
            if (!w_data) begin
              r_state  <= DATA;
              r_bitcnt <= '0;
            end else r_err <= 1'b1;
          end
          DATA: begin
            r_sr     <= {w_data, r_sr[7:1]};
            r_bitcnt <= r_bitcnt + 1'b1;
            if (r_bitcnt == 3'd7) r_state <= PARITY;
          end
          // parity verdict is held until the stop bit so a bad frame raises one error
          PARITY: begin
            r_par_ok <= ^{r_sr, w_data};
            r_state  <= STOP;
          end
          default: begin
            r_state <= IDLE;
            if (w_data && r_par_ok) begin
              r_byte_vld <= 1'b1;
              r_byte     <= r_sr;
            end else r_err <= 1'b1;
          end
        endcase
      end
      if (r_byte_vld) begin
        if (|r_e1_skip) r_e1_skip <= r_e1_skip - 1'b1;
        else if (r_byte == PS2_PAUSE) r_e1_skip <= 3'd7;
        else if (r_byte == PS2_EXT) r_ext <= 1'b1;
        else if (r_byte == PS2_BRK) r_brk <= 1'b1;
        else if (!(is_status(r_byte) && !r_ext && !r_brk)) begin
          r_key <= {~r_key.toggle, ~r_brk, r_ext, r_byte};
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end
    end
  end
endmodule
